// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, optional zero pad, CRC-32 FCS and inter-frame gap.
// Define GMII_TX_FRAMER_PAD_EN to compile in padding of short payloads to MIN_PAYLOAD bytes.
module gmii_tx_framer #(
   parameter int unsigned IFG_CYCLES  = 12,
   parameter int unsigned MIN_PAYLOAD = 60
) (
   input  logic       gmii_tx_clk,
   input  logic       reset,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic       gmii_tx_en,
   output logic [7:0] gmii_txd,
   output logic       busy,
   output logic       tx_underrun
);

   if (IFG_CYCLES < 1 || IFG_CYCLES > 255 || MIN_PAYLOAD > 2047) begin : g_param_check
      $error("gmii_tx_framer: parameter out of range");
   end

`ifdef GMII_TX_FRAMER_PAD_EN
   typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StPad, StFcs, StIfg} state_e;
   localparam logic [10:0] MinLen = 11'(MIN_PAYLOAD);
`else
   typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StFcs, StIfg} state_e;
`endif

   localparam logic [7:0] IfgLast = 8'(IFG_CYCLES);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [10:0] byte_cnt_q, byte_cnt_d;
   logic [31:0] crc_q, crc_d;
   logic        last_q, last_d;
   logic        bad_q, bad_d;
   logic        tx_en_q, tx_en_d;
   logic [7:0]  txd_q, txd_d;
   logic        underrun_q, underrun_d;
   logic        crc_en;
   logic        go_fcs;
   logic [31:0] fcs_word;

   // Reflected CRC-32, one bit per step, LSB of the byte first.
   function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
         else                c = c >> 1;
      end
      return c;
   endfunction

   // A starved frame sends the raw register so the receiver sees a bad FCS.
   assign fcs_word = bad_q ? crc_q : ~crc_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      byte_cnt_d = byte_cnt_q;
      crc_d      = crc_q;
      last_d     = last_q;
      bad_d      = bad_q;
      tx_en_d    = 1'b0;
      txd_d      = 8'h00;
      underrun_d = 1'b0;
      crc_en     = 1'b0;
      go_fcs     = 1'b0;
      s_ready    = 1'b0;

      case (state_q)
         StIdle: begin
            if (s_valid) begin
               state_d    = StPre;
               cnt_d      = 8'd1;
               byte_cnt_d = '0;
               crc_d      = '1;
               last_d     = 1'b0;
               bad_d      = 1'b0;
               tx_en_d    = 1'b1;
               txd_d      = 8'h55;
            end
         end
         StPre: begin
            tx_en_d = 1'b1;
            if (cnt_q == 8'd7) begin
               state_d = StSfd;
               txd_d   = 8'hD5;
            end else begin
               txd_d = 8'h55;
               cnt_d = cnt_q + 8'd1;
            end
         end
         StSfd, StData: begin
            s_ready = !last_q;
            if (last_q) begin
`ifdef GMII_TX_FRAMER_PAD_EN
               if (byte_cnt_q < MinLen) begin
                  state_d = StPad;
                  tx_en_d = 1'b1;
                  crc_en  = 1'b1;
               end else begin
                  go_fcs = 1'b1;
               end
`else
               go_fcs = 1'b1;
`endif
            end else if (s_valid) begin
               state_d = StData;
               tx_en_d = 1'b1;
               txd_d   = s_data;
               crc_en  = 1'b1;
               last_d  = s_last;
            end else begin
               go_fcs     = 1'b1;
               bad_d      = 1'b1;
               underrun_d = 1'b1;
            end
         end
`ifdef GMII_TX_FRAMER_PAD_EN
         StPad: begin
            if (byte_cnt_q < MinLen) begin
               tx_en_d = 1'b1;
               crc_en  = 1'b1;
            end else begin
               go_fcs = 1'b1;
            end
         end
`endif
         StFcs: begin
            if (cnt_q == 8'd4) begin
               state_d = StIfg;
               cnt_d   = 8'd1;
            end else begin
               tx_en_d = 1'b1;
               txd_d   = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
               cnt_d   = cnt_q + 8'd1;
            end
         end
         StIfg: begin
            if (cnt_q == IfgLast) state_d = StIdle;
            else                  cnt_d   = cnt_q + 8'd1;
         end
         default: state_d = StIdle;
      endcase

      if (go_fcs) begin
         state_d = StFcs;
         cnt_d   = 8'd1;
         tx_en_d = 1'b1;
         txd_d   = bad_d ? crc_q[7:0] : ~crc_q[7:0];
      end

      if (crc_en) begin
         crc_d      = crc_next(crc_q, txd_d);
         byte_cnt_d = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
      end
   end

   always_ff @(posedge gmii_tx_clk) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         byte_cnt_q <= '0;
         crc_q      <= '1;
         last_q     <= 1'b0;
         bad_q      <= 1'b0;
         tx_en_q    <= 1'b0;
         txd_q      <= 8'h00;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         byte_cnt_q <= byte_cnt_d;
         crc_q      <= crc_d;
         last_q     <= last_d;
         bad_q      <= bad_d;
         tx_en_q    <= tx_en_d;
         txd_q      <= txd_d;
         underrun_q <= underrun_d;
      end
   end

   assign gmii_tx_en  = tx_en_q;
   assign gmii_txd    = txd_q;
   assign tx_underrun = underrun_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: expected wire bytes and frame lengths are queued as each
// frame is driven and popped by a monitor as the framer transmits.
module tb_gmii_tx_framer;

   localparam int IFG  = 12;
   localparam int MINP = 60;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] s_data = 8'h00;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic       s_ready;
   logic       gmii_tx_en;
   logic [7:0] gmii_txd;
   logic       busy;
   logic       tx_underrun;

   always #4 clk = ~clk;

   gmii_tx_framer #(
      .IFG_CYCLES  (IFG),
      .MIN_PAYLOAD (MINP)
   ) dut (
      .gmii_tx_clk (clk),
      .reset       (reset),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .gmii_tx_en  (gmii_tx_en),
      .gmii_txd    (gmii_txd),
      .busy        (busy),
      .tx_underrun (tx_underrun)
   );

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   bq_t exp_q;
   int  len_q[$];

   bit          ignore = 1'b0;
   int          run = 0, gap = 0, busy_tail = 0;
   int          last_gap = 0, last_busy_tail = 0;
   int          underruns = 0, ready_gap = 0;
   logic        prev_en = 1'b0, prev_busy = 1'b0;
   logic [31:0] fcs_sh = '0, last_fcs = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fcs_of(input bq_t d);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (d[i]) begin
         c = c ^ {24'd0, d[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   function automatic bq_t mk(input int len, input int seed);
      bq_t q;
      for (int i = 0; i < len; i++) q.push_back(8'((seed * 37) + (i * 13) + (i >> 3)));
      return q;
   endfunction

   task automatic expect_frame(input bq_t p, input bit bad);
      bq_t f;
      logic [31:0] fcs;
      f = p;
`ifdef GMII_TX_FRAMER_PAD_EN
      if (!bad) while (f.size() < MINP) f.push_back(8'h00);
`endif
      fcs = fcs_of(f);
      if (bad) fcs = ~fcs;
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      foreach (f[i]) exp_q.push_back(f[i]);
      for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
      len_q.push_back(8 + f.size() + 4);
   endtask

   // Returns #1 after the edge that accepted the last byte, or byte stop_at if nonzero.
   task automatic drive(input bq_t p, input int stop_at);
      int   idx;
      int   guard;
      logic rdy;
      idx     = 0;
      guard   = 0;
      s_valid = 1'b1;
      s_data  = p[0];
      s_last  = (p.size() == 1);
      while (idx < p.size()) begin
         @(negedge clk);
         rdy = s_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            idx++;
            if (idx == stop_at) break;
            if (idx < p.size()) begin
               s_data = p[idx];
               s_last = (idx == p.size() - 1);
            end
         end
         guard++;
         if (guard > p.size() + 64) begin
            check("drive_timeout", 32'd1, 32'd0);
            break;
         end
      end
      s_last = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (busy && guard < 4000);
      if (busy) check("idle_timeout", 32'd1, 32'd0);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (tx_underrun) underruns++;
      if (s_ready && !gmii_tx_en) ready_gap++;
      if (gmii_tx_en) begin
         if (!prev_en) last_gap = gap;
         run++;
         fcs_sh = {gmii_txd, fcs_sh[31:8]};
         if (!ignore) begin
            if (exp_q.size() == 0) check("unexpected_byte", 32'd1, 32'd0);
            else check("wire_byte", 32'(gmii_txd), 32'(exp_q.pop_front()));
         end
      end else begin
         if (prev_en) begin
            if (!ignore) begin
               if (len_q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
               else check("frame_len", 32'(run), 32'(len_q.pop_front()));
            end
            last_fcs  = fcs_sh;
            run       = 0;
            gap       = 0;
            busy_tail = 0;
         end
         gap++;
         if (busy) begin
            busy_tail++;
            check("ifg_txd", 32'(gmii_txd), 32'd0);
         end
         if (prev_busy && !busy) last_busy_tail = busy_tail;
      end
      prev_en   = gmii_tx_en;
      prev_busy = busy;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t p, p2;
      int  u0;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_tx_en", 32'(gmii_tx_en), 32'd0);
      check("rst_txd", 32'(gmii_txd), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_underrun", 32'(tx_underrun), 32'd0);

      // CRC check vector "123456789"
      p = {};
      for (int i = 0; i < 9; i++) p.push_back(8'(8'h31 + i));
      expect_frame(p, 1'b0);
      drive(p, 0);
      s_valid = 1'b0;
      wait_idle();
`ifndef GMII_TX_FRAMER_PAD_EN
      check("crc_vector_fcs", last_fcs, 32'hCBF43926);
`endif

      // Short payload (padded when padding is compiled in)
      p = mk(14, 1);
      expect_frame(p, 1'b0);
      drive(p, 0);
      s_valid = 1'b0;
      wait_idle();
      check("short_drained", 32'(exp_q.size()), 32'd0);

      // Back-to-back with s_valid held high
      p  = mk(64, 2);
      p2 = mk(64, 3);
      expect_frame(p, 1'b0);
      expect_frame(p2, 1'b0);
      drive(p, 0);
      drive(p2, 0);
      s_valid = 1'b0;
      wait_idle();
      check("b2b_gap", 32'(last_gap), 32'(IFG + 1));
      check("b2b_busy_tail", 32'(last_busy_tail), 32'(IFG));

      // Underrun after 20 of 100 bytes
      u0 = underruns;
      p  = mk(100, 4);
      expect_frame(p[0:19], 1'b1);
      drive(p, 20);
      s_valid = 1'b0;
      wait_idle();
      check("underrun_pulses", 32'(underruns - u0), 32'd1);
      check("underrun_busy_tail", 32'(last_busy_tail), 32'(IFG));

      // Reset while payload byte 30 is on the wire
      ignore = 1'b1;
      p = mk(100, 5);
      drive(p, 30);
      reset   = 1'b1;
      s_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_tx_en", 32'(gmii_tx_en), 32'd0);
      check("midrst_txd", 32'(gmii_txd), 32'd0);
      check("midrst_s_ready", 32'(s_ready), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      ignore = 1'b0;
      check("midrst_queue_empty", 32'(exp_q.size() + len_q.size()), 32'd0);
      p = mk(40, 6);
      expect_frame(p, 1'b0);
      drive(p, 0);
      s_valid = 1'b0;
      wait_idle();

      // 1-byte payload
      p = mk(1, 7);
      expect_frame(p, 1'b0);
      drive(p, 0);
      s_valid = 1'b0;
      wait_idle();
      check("one_byte_busy_tail", 32'(last_busy_tail), 32'(IFG));

      // Full-size payload
      p = mk(1514, 8);
      expect_frame(p, 1'b0);
      drive(p, 0);
      s_valid = 1'b0;
      wait_idle();
      check("big_busy_tail", 32'(last_busy_tail), 32'(IFG));

      check("final_bytes_drained", 32'(exp_q.size()), 32'd0);
      check("final_frames_drained", 32'(len_q.size()), 32'd0);
      check("ready_outside_frame", 32'(ready_gap), 32'd0);
      check("total_underruns", 32'(underruns), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
